// File: rtl/axis_slave.sv
// rtl/axis_slave.sv - AXI-Stream slave: FWFT beat buffer plus per-packet length check
module axis_slave #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_arst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] data_out,
  output logic              last_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              pkt_done,
  output logic [7:0]        pkt_len,
  output logic              len_err
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [8:0]  EXP_LEN = 9'(PKT_LEN);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state, state_next;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [DATA_W:0]   head;
  logic [7:0]        beat_cnt;
  logic [8:0]        beat_inc;
  logic              full, push, pop;

  // tready depends only on registered occupancy, so a pop never bypasses into a full FIFO
  assign full          = (count == DEPTH);
  assign s_axis_tready = !full && !s_axis_arst;
  assign data_valid    = (count != '0);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = data_valid && data_ready;
  assign head          = mem[rd_ptr];
  assign data_out      = data_valid ? head[DATA_W-1:0] : '0;
  assign last_out      = data_valid ? head[DATA_W] : 1'b0;
  assign beat_inc      = {1'b0, beat_cnt} + 9'd1;

  always_ff @(posedge s_axis_aclk) begin
    if (push) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
    if (s_axis_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
    if (s_axis_arst) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (push) begin
      case (state)
        IDLE:    if (!s_axis_tlast) state_next = RECV;
        RECV:    if (s_axis_tlast)  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // beat_cnt holds beats seen before the current one; the tlast beat itself adds one
  always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
    if (s_axis_arst) begin
      beat_cnt <= '0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      len_err  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (push) begin
        if (s_axis_tlast) begin
          beat_cnt <= '0;
          pkt_done <= 1'b1;
          pkt_len  <= beat_inc[8] ? 8'hFF : beat_inc[7:0];
          len_err  <= (beat_inc != EXP_LEN);
        end else if (beat_cnt != 8'hFF) begin
          beat_cnt <= beat_inc[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_slave.sv
// tb/tb_axis_slave.sv - scoreboard bench for axis_slave
module tb_axis_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata;
  logic       tvalid, tlast, tready;
  logic [7:0] data_out;
  logic       last_out, data_valid, data_ready;
  logic       pkt_done, len_err;
  logic [7:0] pkt_len;

  int checks = 0;
  int failures = 0;
  int accepted = 0;
  int max_occ = 0;

  logic [8:0] data_q[$];
  logic [8:0] pkt_q[$];
  logic [8:0] exp_beat, exp_pkt;

  axis_slave #(.DATA_W(8), .FIFO_DEPTH(8), .PKT_LEN(4)) dut (
    .s_axis_aclk   (clk),
    .s_axis_arst   (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (tready),
    .data_out      (data_out),
    .last_out      (last_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .pkt_done      (pkt_done),
    .pkt_len       (pkt_len),
    .len_err       (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_pkt(input logic [7:0] len, input logic err);
    pkt_q.push_back({err, len});
  endtask

  // holds the beat on the bus until it is handshaken; returns at posedge+1
  task automatic send_beat(input logic [7:0] d, input logic l);
    int  n;
    logic acc;
    tvalid = 1'b1; tdata = d; tlast = l;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout beat=%0h actual=not_accepted expected=accepted", d);
    end else begin
      data_q.push_back({l, d});
      accepted++;
    end
    tvalid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_q.size() > max_occ) max_occ = data_q.size();
      if (data_valid && data_ready) begin
        if (data_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=%0h expected=none", {last_out, data_out});
        end else begin
          exp_beat = data_q.pop_front();
          chk("beat", {23'd0, last_out, data_out}, {23'd0, exp_beat});
        end
      end
      if (pkt_done) begin
        if (pkt_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pkt_done actual=len%0d expected=none", pkt_len);
        end else begin
          exp_pkt = pkt_q.pop_front();
          chk("pkt_len", {24'd0, pkt_len}, {24'd0, exp_pkt[7:0]});
          chk("len_err", {31'd0, len_err}, {31'd0, exp_pkt[8]});
        end
      end
    end
  end

  logic vpat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic rpat [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int  beat, n;
    logic acc;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = 8'h00; data_ready = 1'b0;
    #23;
    chk("rst_data_valid", {31'd0, data_valid}, 0);
    chk("rst_tready", {31'd0, tready}, 0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 0);
    chk("rst_pkt_len", {24'd0, pkt_len}, 0);
    chk("rst_len_err", {31'd0, len_err}, 0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("tready_after_rst", {31'd0, tready}, 1);

    // 1: nominal 4-beat packet
    data_ready = 1'b1;
    send_beat(8'h05, 1'b0);
    chk("latency_valid", {31'd0, data_valid}, 1);
    chk("latency_data", {24'd0, data_out}, 32'h05);
    send_beat(8'h0A, 1'b0);
    send_beat(8'h0F, 1'b0);
    expect_pkt(8'd4, 1'b0);
    send_beat(8'h14, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // 2: fill to full with consumer stalled, then drain
    data_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
    tvalid = 1'b1; tdata = 8'h09; tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("full_tready", {31'd0, tready}, 0);
    chk("full_accept_count", accepted, 12);
    data_ready = 1'b1;
    #1 chk("no_bypass_tready", {31'd0, tready}, 0);
    @(posedge clk); #1;
    chk("tready_after_pop", {31'd0, tready}, 1);
    send_beat(8'h09, 1'b0);
    expect_pkt(8'd10, 1'b1);
    send_beat(8'h0A, 1'b1);
    repeat (10) @(posedge clk);
    #1;

    // 3: short packet then nominal packet
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    expect_pkt(8'd3, 1'b1);
    send_beat(8'h33, 1'b1);
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    expect_pkt(8'd4, 1'b0);
    send_beat(8'h04, 1'b1);

    // 4: single-beat packet, back-to-back 4-beat packet
    expect_pkt(8'd1, 1'b1);
    send_beat(8'h7F, 1'b1);
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b0);
    send_beat(8'hA3, 1'b0);
    expect_pkt(8'd4, 1'b0);
    send_beat(8'hA4, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // 5: asynchronous reset mid-packet discards buffered beats
    data_ready = 1'b0;
    send_beat(8'h51, 1'b0);
    send_beat(8'h52, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort_data_valid", {31'd0, data_valid}, 0);
    chk("abort_tready", {31'd0, tready}, 0);
    data_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    data_ready = 1'b1;
    send_beat(8'h61, 1'b0);
    send_beat(8'h62, 1'b0);
    send_beat(8'h63, 1'b0);
    expect_pkt(8'd4, 1'b0);
    send_beat(8'h64, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // 6: gapped tvalid with toggling consumer
    beat = 0; n = 0;
    for (int i = 0; i < 6; i++) begin
      tvalid = vpat[i];
      tdata = 8'(8'h41 + beat);
      tlast = (beat == 3);
      data_ready = rpat[i];
      if (tvalid && tlast) expect_pkt(8'd4, 1'b0);
      @(negedge clk);
      acc = tvalid && tready;
      @(posedge clk); #1;
      if (acc) begin
        data_q.push_back({tlast, tdata});
        beat++;
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("gapped_accept_count", beat, 4);

    data_ready = 1'b1;
    while ((data_q.size() != 0 || pkt_q.size() != 0) && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_data_left", data_q.size(), 0);
    chk("drain_pkt_left", pkt_q.size(), 0);
    chk("max_occupancy", max_occ, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
